mapped_data_memory: RTL and testbench
=====================================

MAPPED_DATA_MEMORY -- requirements
Module: mapped_data_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter ADDR_W, default 15, CPU address width.
REQ-003 SHALL have parameter RAM_WORDS, default 16384, general RAM words at base 0.
REQ-004 SHALL have parameter SCREEN_WORDS, default 8192, screen words at base RAM_WORDS.
REQ-005 SHALL have parameter KB_CLEAR_ON_READ, default 0, 1 = keyboard register clears after a CPU read.
REQ-006 SHALL have one clock and an asynchronous, active-high reset, as listed below.
REQ-007 clk  in  1  sole clock, all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 adr  in  ADDR_W  CPU word address.
REQ-010 load  in  1  CPU write enable.
REQ-011 rd_en  in  1  CPU read enable.
REQ-012 d_in  in  DATA_W  CPU write data.
REQ-013 d_out  out  DATA_W  CPU read data, registered.
REQ-014 err  out  1  one-cycle pulse on unmapped access or keyboard write.
REQ-015 kb_in  in  DATA_W  keyboard scan code.
REQ-016 kb_valid  in  1  kb_in strobe.
REQ-017 scan_start  in  1  start-of-frame request from display.
REQ-018 scan_ready  in  1  display accepts scan word.
REQ-019 scan_valid  out  1  scan_data valid.
REQ-020 scan_data  out  DATA_W  screen word at scan_index.
REQ-021 scan_last  out  1  qualifies final screen word.

Function
REQ-022 Map: RAM [0, RAM_WORDS-1]; SCREEN [RAM_WORDS, RAM_WORDS+SCREEN_WORDS-1]; KBD at RAM_WORDS+SCREEN_WORDS; all higher addresses unmapped.
REQ-023 Write: load=1 to RAM/SCREEN updates word at clk edge; load=1 to KBD or unmapped changes nothing, err=1 next cycle.
REQ-024 Read: rd_en=1 gives d_out = addressed word one cycle later; KBD returns kb_reg; unmapped returns 0, err=1; with rd_en=0, d_out holds.
REQ-025 Same-cycle load and rd_en to one address returns the old data.
REQ-026 kb_reg loads kb_in when kb_valid=1; when KB_CLEAR_ON_READ=1 a KBD read clears it to 0 next cycle; simultaneous kb_valid and KBD read: new kb_in wins.
REQ-027 Scanner FSM: IDLE, SCAN; scan_start in IDLE -> SCAN, index=0; scan_start in SCAN ignored.
REQ-028 In SCAN, scan_valid rises within 2 cycles of entry; scan_data = SCREEN[index]; index advances only on scan_valid && scan_ready.
REQ-029 Under backpressure (scan_ready=0), scan_valid and scan_data hold stable.
REQ-030 scan_last=1 exactly when index = SCREEN_WORDS-1; its accepted transfer returns FSM to IDLE, scan_valid=0, index=0.
REQ-031 Scanner uses its own read port; CPU traffic never stalls it; a CPU write to the word being presented becomes visible no later than that word's next presentation.

Reset
REQ-032 reset asynchronously forces d_out=0, err=0, kb_reg=0, FSM=IDLE, index=0, scan_valid=0, scan_last=0, scan_data=0.
REQ-033 Memory contents are not reset; reset mid-scan aborts the frame, no partial completion.

Structure
REQ-034 Shared package holds region base/limit constants derived from parameters and the scanner state enum.
REQ-035 One sub-module, screen_scanner (FSM, index counter, output holding register); storage and decode stay in top.

Verification
REQ-036 Write 0x1234 to adr 5, read adr 5 -> d_out=0x1234 one cycle after rd_en.
REQ-037 kb_valid with 0x0041, read adr 24576 -> 0x0041; KB_CLEAR_ON_READ=1: second read -> 0x0000.
REQ-038 Write adr 24576 or read adr 24577 -> err pulses one cycle, memory unchanged, d_out=0 on read.
REQ-039 Preload SCREEN[i]=i, scan_start, scan_ready=1 -> 8192 words 0..8191, scan_last on word 8191, then IDLE.
REQ-040 scan_ready toggled randomly mid-frame -> no word dropped or duplicated, data stable while stalled.
REQ-041 reset asserted at word 100 -> scan_valid=0 at once; new scan_start restarts at word 0.

Source files
------------

// File: rtl/mapped_data_memory_pkg.sv
// rtl/mapped_data_memory_pkg.sv - address map helpers and scanner state type
// Region boundaries are computed from the top-level sizing parameters.
package mapped_data_memory_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  localparam int DEF_RAM_WORDS    = 16384;
  localparam int DEF_SCREEN_WORDS = 8192;

  function automatic logic [31:0] screen_base(input int ram_words);
    return 32'(ram_words);
  endfunction

  function automatic logic [31:0] screen_limit(input int ram_words, input int screen_words);
    return 32'(ram_words + screen_words - 1);
  endfunction

  function automatic logic [31:0] kbd_addr(input int ram_words, input int screen_words);
    return 32'(ram_words + screen_words);
  endfunction

endpackage

// File: rtl/mapped_data_memory_if.sv
// rtl/mapped_data_memory_if.sv - CPU word-access bus
interface mapped_data_memory_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) ();
  logic [ADDR_W-1:0] adr;
  logic              load;
  logic              rd_en;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] d_out;
  logic              err;

  modport master (output adr, load, rd_en, d_in, input d_out, err);
  modport slave  (input adr, load, rd_en, d_in, output d_out, err);
endinterface

// File: rtl/mapped_data_memory_screen_scanner.sv
// rtl/mapped_data_memory_screen_scanner.sv - streams the screen region one word per accepted beat
// rd_addr is the word needed at the next edge, so back-to-back beats run without bubbles.
module screen_scanner
  import mapped_data_memory_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int SCREEN_WORDS = 8192,
  parameter int IDX_W        = $clog2(SCREEN_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_start,
  input  logic              scan_ready,
  output logic [IDX_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              scan_valid,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_last
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCREEN_WORDS - 1);

  scan_state_t       state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              valid_q;
  logic              last_q;
  logic [DATA_W-1:0] data_q;

  assign rd_addr    = (valid_q && scan_ready) ? idx_q + 1'b1 : idx_q;
  assign scan_valid = valid_q;
  assign scan_data  = data_q;
  assign scan_last  = last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (scan_start) begin
            state_q <= ST_SCAN;
            idx_q   <= '0;
          end
        end
        ST_SCAN: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
            data_q  <= rd_data;
            last_q  <= (idx_q == LAST_IDX);
          end else if (scan_ready) begin
            if (last_q) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              idx_q   <= '0;
            end else begin
              idx_q  <= rd_addr;
              data_q <= rd_data;
              last_q <= (rd_addr == LAST_IDX);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mapped_data_memory.sv
// rtl/mapped_data_memory.sv - RAM, screen and keyboard behind one CPU port, plus a screen scanner
module mapped_data_memory
  import mapped_data_memory_pkg::*;
#(
  parameter int DATA_W           = 16,
  parameter int ADDR_W           = 15,
  parameter int RAM_WORDS        = DEF_RAM_WORDS,
  parameter int SCREEN_WORDS     = DEF_SCREEN_WORDS,
  parameter bit KB_CLEAR_ON_READ = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  mapped_data_memory_if.slave  cpu,
  input  logic [DATA_W-1:0]    kb_in,
  input  logic                 kb_valid,
  input  logic                 scan_start,
  input  logic                 scan_ready,
  output logic                 scan_valid,
  output logic [DATA_W-1:0]    scan_data,
  output logic                 scan_last
);
  localparam logic [31:0] SCR_BASE  = screen_base(RAM_WORDS);
  localparam logic [31:0] SCR_LIMIT = screen_limit(RAM_WORDS, SCREEN_WORDS);
  localparam logic [31:0] KBD_ADDR  = kbd_addr(RAM_WORDS, SCREEN_WORDS);
  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          SCR_AW    = $clog2(SCREEN_WORDS);

  logic [DATA_W-1:0] ram_mem [RAM_WORDS];
  logic [DATA_W-1:0] scr_mem [SCREEN_WORDS];

  logic [31:0]       adr_w;
  logic              is_ram, is_scr, is_kbd;
  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;
  logic [SCR_AW-1:0] scan_rd_addr;
  logic [DATA_W-1:0] scan_word;

  logic [DATA_W-1:0] d_out_d, d_out_q;
  logic              err_d, err_q;
  logic [DATA_W-1:0] kb_d, kb_q;

  assign adr_w   = 32'(cpu.adr);
  assign is_ram  = adr_w < 32'(RAM_WORDS);
  assign is_scr  = (adr_w >= SCR_BASE) && (adr_w <= SCR_LIMIT);
  assign is_kbd  = adr_w == KBD_ADDR;
  assign ram_idx = RAM_AW'(cpu.adr);
  assign scr_idx = SCR_AW'(adr_w - SCR_BASE);

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (cpu.load && is_ram) ram_mem[ram_idx] <= cpu.d_in;
    if (cpu.load && is_scr) scr_mem[scr_idx] <= cpu.d_in;
  end

  assign scan_word = scr_mem[scan_rd_addr];

  always_comb begin
    d_out_d = d_out_q;
    err_d   = 1'b0;
    kb_d    = kb_q;
    if (cpu.rd_en) begin
      if (is_ram)      d_out_d = ram_mem[ram_idx];
      else if (is_scr) d_out_d = scr_mem[scr_idx];
      else if (is_kbd) d_out_d = kb_q;
      else begin
        d_out_d = '0;
        err_d   = 1'b1;
      end
    end
    if (cpu.load && !(is_ram || is_scr)) err_d = 1'b1;
    if (kb_valid) kb_d = kb_in;
    else if (KB_CLEAR_ON_READ && cpu.rd_en && is_kbd) kb_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out_q <= '0;
      err_q   <= 1'b0;
      kb_q    <= '0;
    end else begin
      d_out_q <= d_out_d;
      err_q   <= err_d;
      kb_q    <= kb_d;
    end
  end

  assign cpu.d_out = d_out_q;
  assign cpu.err   = err_q;

  screen_scanner #(
    .DATA_W       (DATA_W),
    .SCREEN_WORDS (SCREEN_WORDS),
    .IDX_W        (SCR_AW)
  ) u_screen_scanner (
    .clk        (clk),
    .reset      (reset),
    .scan_start (scan_start),
    .scan_ready (scan_ready),
    .rd_addr    (scan_rd_addr),
    .rd_data    (scan_word),
    .scan_valid (scan_valid),
    .scan_data  (scan_data),
    .scan_last  (scan_last)
  );

endmodule

// File: tb/tb_mapped_data_memory.sv
// tb/tb_mapped_data_memory.sv - directed bench; dut0 keeps the keyboard value, dut1 clears it on read
module tb_mapped_data_memory;
  localparam int DW  = 16;
  localparam int AW  = 15;
  localparam int NS  = 8192;
  localparam int SCR = 16384;
  localparam int KBD = 24576;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mapped_data_memory_if #(.DATA_W(DW), .ADDR_W(AW)) cpu0 ();
  mapped_data_memory_if #(.DATA_W(DW), .ADDR_W(AW)) cpu1 ();
  assign cpu1.adr   = cpu0.adr;
  assign cpu1.load  = cpu0.load;
  assign cpu1.rd_en = cpu0.rd_en;
  assign cpu1.d_in  = cpu0.d_in;

  logic [DW-1:0] kb_in;
  logic          kb_valid, scan_start, scan_ready;
  logic          sv0, sl0, sv1, sl1;
  logic [DW-1:0] sd0, sd1;

  mapped_data_memory #(.KB_CLEAR_ON_READ(1'b0)) dut0 (
    .clk(clk), .reset(reset), .cpu(cpu0), .kb_in(kb_in), .kb_valid(kb_valid),
    .scan_start(scan_start), .scan_ready(scan_ready),
    .scan_valid(sv0), .scan_data(sd0), .scan_last(sl0)
  );

  mapped_data_memory #(.KB_CLEAR_ON_READ(1'b1)) dut1 (
    .clk(clk), .reset(reset), .cpu(cpu1), .kb_in(kb_in), .kb_valid(kb_valid),
    .scan_start(scan_start), .scan_ready(scan_ready),
    .scan_valid(sv1), .scan_data(sd1), .scan_last(sl1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    cpu0.adr = AW'(a); cpu0.d_in = d; cpu0.load = 1'b1; cpu0.rd_en = 1'b0;
    tick();
    cpu0.load = 1'b0;
  endtask

  task automatic rd(input int a);
    cpu0.adr = AW'(a); cpu0.rd_en = 1'b1; cpu0.load = 1'b0;
    tick();
    cpu0.rd_en = 1'b0;
  endtask

  int n, cyc, errs, lasts, lastpos, exp_w, seq_errs, stable_errs, w;
  logic held_v, done;
  logic [DW-1:0] held_d;

  initial begin
    cpu0.adr = '0; cpu0.load = 1'b0; cpu0.rd_en = 1'b0; cpu0.d_in = '0;
    kb_in = '0; kb_valid = 1'b0; scan_start = 1'b0; scan_ready = 1'b0;
    tick(); tick();
    check("rst_dout", cpu0.d_out, 0);
    check("rst_err", cpu0.err, 0);
    check("rst_valid", sv0, 0);
    check("rst_last", sl0, 0);
    check("rst_data", sd0, 0);
    reset = 1'b0;
    tick();

    wr(5, 16'h1234); rd(5);
    check("ram_rd", cpu0.d_out, 16'h1234);
    check("ram_rd_err", cpu0.err, 0);
    tick();
    check("dout_hold", cpu0.d_out, 16'h1234);
    wr(16383, 16'hC0DE); rd(16383);
    check("ram_top", cpu0.d_out, 16'hC0DE);
    wr(SCR + 3, 16'hBEEF); rd(SCR + 3);
    check("scr_rd", cpu0.d_out, 16'hBEEF);
    wr(KBD - 1, 16'h0F0F); rd(KBD - 1);
    check("scr_top", cpu0.d_out, 16'h0F0F);
    cpu0.adr = AW'(5); cpu0.d_in = 16'h5555; cpu0.load = 1'b1; cpu0.rd_en = 1'b1;
    tick();
    cpu0.load = 1'b0; cpu0.rd_en = 1'b0;
    check("rw_same_old", cpu0.d_out, 16'h1234);
    rd(5);
    check("rw_same_new", cpu0.d_out, 16'h5555);

    kb_in = 16'h0041; kb_valid = 1'b1; tick(); kb_valid = 1'b0;
    rd(KBD);
    check("kb0_rd1", cpu0.d_out, 16'h0041);
    check("kb1_rd1", cpu1.d_out, 16'h0041);
    rd(KBD);
    check("kb0_rd2", cpu0.d_out, 16'h0041);
    check("kb1_rd2_clr", cpu1.d_out, 16'h0000);
    kb_in = 16'h0043; kb_valid = 1'b1; tick();
    kb_in = 16'h0044; rd(KBD); kb_valid = 1'b0;
    check("kb1_simul_old", cpu1.d_out, 16'h0043);
    rd(KBD);
    check("kb1_new_wins", cpu1.d_out, 16'h0044);
    check("kb0_new", cpu0.d_out, 16'h0044);

    wr(KBD, 16'h7777);
    check("kbd_wr_err", cpu0.err, 1);
    tick();
    check("err_pulse_end", cpu0.err, 0);
    rd(KBD);
    check("kbd_wr_ignored", cpu0.d_out, 16'h0044);
    rd(KBD + 1);
    check("unmap_rd_zero", cpu0.d_out, 0);
    check("unmap_rd_err", cpu0.err, 1);
    tick();
    check("unmap_err_end", cpu0.err, 0);
    wr(30000, 16'h1111);
    check("unmap_wr_err", cpu0.err, 1);
    rd(5);
    check("ram_intact", cpu0.d_out, 16'h5555);

    for (int i = 0; i < NS; i++) wr(SCR + i, DW'(i));

    scan_ready = 1'b1; scan_start = 1'b1; tick(); scan_start = 1'b0;
    w = 0;
    while (!sv0 && w < 3) begin tick(); w++; end
    check("valid_latency", sv0, 1);
    n = 0; cyc = 0; errs = 0; lasts = 0; lastpos = -1;
    while (n < NS && cyc < 20000) begin
      if (sv0) begin
        if (sd0 !== DW'(n)) errs++;
        if (sl0) begin lasts++; lastpos = n; end
        n++;
      end
      tick(); cyc++;
    end
    check("f1_words", n, NS);
    check("f1_data_errs", errs, 0);
    check("f1_last_cnt", lasts, 1);
    check("f1_last_pos", lastpos, NS - 1);
    check("f1_idle", sv0, 0);

    scan_start = 1'b1; tick(); scan_start = 1'b0;
    cpu0.adr = AW'(5); cpu0.rd_en = 1'b1;
    exp_w = 0; cyc = 0; seq_errs = 0; stable_errs = 0; held_v = 1'b0; done = 1'b0;
    while (!done && cyc < 40000) begin
      if (held_v && (!sv0 || sd0 !== held_d)) stable_errs++;
      scan_ready = ($urandom_range(0, 3) != 0);
      scan_start = (cyc == 500);
      held_v = 1'b0;
      if (sv0) begin
        if (scan_ready) begin
          if (sd0 !== DW'(exp_w)) seq_errs++;
          if (sl0 !== (exp_w == NS - 1)) seq_errs++;
          if (sl0) done = 1'b1;
          exp_w++;
        end else begin
          held_v = 1'b1; held_d = sd0;
        end
      end
      tick(); cyc++;
    end
    scan_start = 1'b0; cpu0.rd_en = 1'b0;
    check("bp_words", exp_w, NS);
    check("bp_seq_errs", seq_errs, 0);
    check("bp_stable_errs", stable_errs, 0);
    check("bp_idle", sv0, 0);
    check("bp_cpu_rd", cpu0.d_out, 16'h5555);

    wr(SCR, 16'hA5A5);
    scan_ready = 1'b1; scan_start = 1'b1; tick(); scan_start = 1'b0;
    n = 0; cyc = 0;
    while (n < 100 && cyc < 1000) begin
      if (sv0) n++;
      tick(); cyc++;
    end
    check("pre_rst_word", sd0, 100);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", sv0, 0);
    check("mid_rst_data", sd0, 0);
    check("mid_rst_dout", cpu0.d_out, 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_idle", sv0, 0);
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    tick();
    check("restart_valid", sv0, 1);
    check("restart_word0", sd0, 16'hA5A5);
    tick();
    check("restart_word1", sd0, 1);
    rd(5);
    check("mem_kept", cpu0.d_out, 16'h5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
